// File: rtl/led_scan_pkg.sv
// Shared types and elaboration helpers for the LED scan sequencer.
package led_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_BLANK
  } scan_state_t;

  // Width of the shared hold/blank down-counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned blank_cycles);
    int unsigned w_max;
    w_max = (hold_cycles > blank_cycles) ? hold_cycles : blank_cycles;
    if (w_max < 2) w_max = 2;
    return $clog2(w_max);
  endfunction

endpackage

// File: rtl/led_scan_controller_if.sv
// Valid/ready handshake carrying a new cell generation from the game core.
interface led_scan_controller_if #(
  parameter int N = 8
) ();

  logic [N*N-1:0] cells_in;
  logic           cells_valid;
  logic           cells_ready;

  modport master (
    output cells_in,
    output cells_valid,
    input  cells_ready
  );

  modport slave (
    input  cells_in,
    input  cells_valid,
    output cells_ready
  );

endinterface

// File: rtl/grid_double_buffer.sv
// Pending/display grid pair: accepts a generation into pending and moves it to
// the display buffer only when the scan FSM strobes a frame-start swap.
module grid_double_buffer #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  swap,
  led_scan_controller_if.slave  cells_if,
  output logic [N*N-1:0]        cells_out
);

  logic [N*N-1:0] r_pending;
  logic [N*N-1:0] r_display;
  logic           r_pending_full;
  logic           w_accept;

  assign cells_if.cells_ready = ~r_pending_full;
  assign w_accept             = cells_if.cells_valid & ~r_pending_full;
  assign cells_out            = r_display;

  // A swap only happens while pending is full, when ready is low, so swap and
  // accept never collide on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending      <= '0;
      r_display      <= '0;
      r_pending_full <= 1'b0;
    end else begin
      if (swap && r_pending_full) begin
        r_display      <= r_pending;
        r_pending_full <= 1'b0;
      end
      if (w_accept) begin
        r_pending      <= cells_if.cells_in;
        r_pending_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_scan_controller.sv
// Column-multiplex scan sequencer with tear-free, frame-aligned grid updates
// feeding led_array_driver.
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter  int N               = 8,
  parameter  int COL_HOLD_CYCLES = 1000,
  parameter  int BLANK_CYCLES    = 100,
  localparam int XBITS           = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  led_scan_controller_if.slave  cells_if,
  output logic [XBITS:0]        x,
  output logic                  drive_ena,
  output logic [N*N-1:0]        cells_out,
  output logic                  frame_start
);

  localparam int unsigned    CW         = cnt_width(COL_HOLD_CYCLES, BLANK_CYCLES);
  localparam logic [CW-1:0]  HOLD_LOAD  = CW'(COL_HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  BLANK_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [XBITS:0] LAST_COL   = (XBITS + 1)'(N - 1);

  scan_state_t     r_state;
  scan_state_t     w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [XBITS:0]  r_x;
  logic [XBITS:0]  w_x_nxt;
  logic            r_drive_ena;
  logic            r_frame_start;
  logic            w_frame_nxt;
  logic            w_col_adv;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_frame_nxt = 1'b0;
    w_col_adv   = 1'b0;

    if (!ena) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_x_nxt     = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = HOLD_LOAD;
          w_x_nxt     = '0;
          w_frame_nxt = 1'b1;
        end
        ST_DRIVE: begin
          if (r_cnt == '0) begin
            if (BLANK_CYCLES == 0) begin
              w_col_adv = 1'b1;
            end else begin
              w_state_nxt = ST_BLANK;
              w_cnt_nxt   = BLANK_LOAD;
            end
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
        ST_BLANK: begin
          if (r_cnt == '0) w_col_adv = 1'b1;
          else             w_cnt_nxt = r_cnt - CW'(1);
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_x_nxt     = '0;
        end
      endcase

      // Entering the next column's DRIVE; wrapping past the last column is a frame start.
      if (w_col_adv) begin
        w_state_nxt = ST_DRIVE;
        w_cnt_nxt   = HOLD_LOAD;
        if (r_x == LAST_COL) begin
          w_x_nxt     = '0;
          w_frame_nxt = 1'b1;
        end else begin
          w_x_nxt = r_x + (XBITS + 1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_x           <= '0;
      r_drive_ena   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_x           <= w_x_nxt;
      r_drive_ena   <= (w_state_nxt == ST_DRIVE);
      r_frame_start <= w_frame_nxt;
    end
  end

  grid_double_buffer #(
    .N(N)
  ) u_grid_double_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .swap      (w_frame_nxt),
    .cells_if  (cells_if),
    .cells_out (cells_out)
  );

  assign x           = r_x;
  assign drive_ena   = r_drive_ena;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_led_scan_controller.sv
// Bench for led_scan_controller: two builds (BLANK_CYCLES=1 and 0) against a
// frame-time reference model.
module tb_led_scan_controller;

  localparam int N    = 8;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  led_scan_controller_if #(.N(N)) if0 ();
  led_scan_controller_if #(.N(N)) if1 ();

  logic [3:0]  o_x   [2];
  logic        o_de  [2];
  logic        o_fs  [2];
  logic [63:0] o_co  [2];
  logic        o_rdy [2];

  assign o_rdy[0] = if0.cells_ready;
  assign o_rdy[1] = if1.cells_ready;

  led_scan_controller #(.N(N), .COL_HOLD_CYCLES(HOLD), .BLANK_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cells_if(if0.slave),
    .x(o_x[0]), .drive_ena(o_de[0]), .cells_out(o_co[0]), .frame_start(o_fs[0])
  );

  led_scan_controller #(.N(N), .COL_HOLD_CYCLES(HOLD), .BLANK_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cells_if(if1.slave),
    .x(o_x[1]), .drive_ena(o_de[1]), .cells_out(o_co[1]), .frame_start(o_fs[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position in the frame as a plain cycle count since the frame began.
  int          BLK [2] = '{1, 0};
  bit          m_run  [2];
  int          m_t    [2];
  bit          m_full [2];
  logic [63:0] m_pend [2];
  logic [63:0] m_disp [2];
  logic [3:0]  e_x    [2];
  bit          e_de   [2];
  bit          e_fs   [2];
  bit          e_rdy  [2];
  logic [63:0] e_co   [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_t[i] = 0; m_full[i] = 0; m_pend[i] = '0; m_disp[i] = '0;
      e_x[i] = '0; e_de[i] = 0; e_fs[i] = 0; e_rdy[i] = 1; e_co[i] = '0;
    end
  endtask

  task automatic tick();
    bit          acc [2];
    logic [63:0] din [2];
    bit          en;
    acc[0] = (if0.cells_valid === 1'b1) && !m_full[0];
    acc[1] = (if1.cells_valid === 1'b1) && !m_full[1];
    din[0] = if0.cells_in;
    din[1] = if1.cells_in;
    en     = (ena === 1'b1);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int p;
      bit fsn;
      p = HOLD + BLK[i];
      if (!en)             m_run[i] = 0;
      else if (!m_run[i]) begin m_run[i] = 1; m_t[i] = 0; end
      else                 m_t[i] = (m_t[i] + 1) % (N * p);
      fsn = m_run[i] && (m_t[i] == 0);
      if (fsn && m_full[i]) begin m_disp[i] = m_pend[i]; m_full[i] = 0; end
      if (acc[i]) begin m_pend[i] = din[i]; m_full[i] = 1; end
      e_x[i]   = m_run[i] ? 4'((m_t[i] / p) % N) : 4'd0;
      e_de[i]  = m_run[i] && ((m_t[i] % p) < HOLD);
      e_fs[i]  = fsn;
      e_co[i]  = m_disp[i];
      e_rdy[i] = !m_full[i];
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0;
    if0.cells_valid = 1'b0; if0.cells_in = '0;
    if1.cells_valid = 1'b0; if1.cells_in = '0;
    model_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      checks += 5;
      if (o_x[i] !== 4'd0)    begin errors++; $display("FAIL reset_x[%0d] got %0d want 0", i, o_x[i]); end
      if (o_de[i] !== 1'b0)   begin errors++; $display("FAIL reset_de[%0d] got %b want 0", i, o_de[i]); end
      if (o_fs[i] !== 1'b0)   begin errors++; $display("FAIL reset_fs[%0d] got %b want 0", i, o_fs[i]); end
      if (o_co[i] !== 64'h0)  begin errors++; $display("FAIL reset_co[%0d] got %h want 0", i, o_co[i]); end
      if (o_rdy[i] !== 1'b1)  begin errors++; $display("FAIL reset_rdy[%0d] got %b want 1", i, o_rdy[i]); end
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks += 2;
        if (o_de[i] !== 1'b0) begin errors++; $display("FAIL idle_de[%0d] got %b want 0", i, o_de[i]); end
        if (o_x[i] !== 4'd0)  begin errors++; $display("FAIL idle_x[%0d] got %0d want 0", i, o_x[i]); end
      end
    end
  endtask

  task automatic test_scan();
    int last_fs [2] = '{-1, -1};
    int n_fs    [2] = '{0, 0};
    ena = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks += 3;
        if (o_x[i] !== e_x[i])   begin errors++; $display("FAIL scan_x[%0d] c=%0d got %0d want %0d", i, c, o_x[i], e_x[i]); end
        if (o_de[i] !== e_de[i]) begin errors++; $display("FAIL scan_de[%0d] c=%0d got %b want %b", i, c, o_de[i], e_de[i]); end
        if (o_fs[i] !== e_fs[i]) begin errors++; $display("FAIL scan_fs[%0d] c=%0d got %b want %b", i, c, o_fs[i], e_fs[i]); end
        if (o_fs[i] === 1'b1) begin
          n_fs[i]++;
          if (last_fs[i] >= 0) begin
            checks++;
            if (c - last_fs[i] != N * (HOLD + BLK[i])) begin
              errors++; $display("FAIL frame_period[%0d] got %0d want %0d", i, c - last_fs[i], N * (HOLD + BLK[i]));
            end
          end
          last_fs[i] = c;
        end
      end
    end
    checks += 2;
    if (n_fs[0] != 3) begin errors++; $display("FAIL frame_count[0] got %0d want 3", n_fs[0]); end
    if (n_fs[1] != 4) begin errors++; $display("FAIL frame_count[1] got %0d want 4", n_fs[1]); end
  endtask

  task automatic test_swap();
    bit seen = 0;
    for (int c = 0; c < 100 && m_t[0] != 12; c++) tick();
    if0.cells_in = 64'hA5; if0.cells_valid = 1'b1;
    tick();
    if0.cells_valid = 1'b0;
    checks += 2;
    if (o_rdy[0] !== 1'b0)   begin errors++; $display("FAIL swap_rdy_drop got %b want 0", o_rdy[0]); end
    if (o_co[0] !== 64'h0)   begin errors++; $display("FAIL swap_co_early got %h want 0", o_co[0]); end
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      checks += 2;
      if (o_co[0] !== e_co[0])   begin errors++; $display("FAIL swap_co got %h want %h", o_co[0], e_co[0]); end
      if (o_rdy[0] !== e_rdy[0]) begin errors++; $display("FAIL swap_rdy got %b want %b", o_rdy[0], e_rdy[0]); end
      if (o_fs[0] === 1'b1) begin
        seen = 1;
        checks += 2;
        if (o_co[0] !== 64'hA5) begin errors++; $display("FAIL swap_co_at_frame got %h want a5", o_co[0]); end
        if (o_rdy[0] !== 1'b1)  begin errors++; $display("FAIL swap_rdy_back got %b want 1", o_rdy[0]); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL swap_timeout got no frame_start want one"); end
  endtask

  task automatic test_hold_valid();
    int  fs_c = -1, acc_c = -1;
    bit  seen = 0;
    for (int c = 0; c < 100 && m_t[0] != 5; c++) tick();
    if0.cells_in = 64'h11; if0.cells_valid = 1'b1;
    tick();
    if0.cells_in = 64'h3C;
    for (int c = 0; c < 100 && acc_c < 0; c++) begin
      bit r;
      r = o_rdy[0];
      tick();
      if (r) acc_c = c;
      if (o_fs[0] === 1'b1) fs_c = c;
    end
    if0.cells_valid = 1'b0;
    checks += 3;
    if (acc_c < 0 || acc_c != fs_c + 1) begin errors++; $display("FAIL hold_accept_cycle got %0d want %0d", acc_c, fs_c + 1); end
    if (o_co[0] !== 64'h11) begin errors++; $display("FAIL hold_first_grid got %h want 11", o_co[0]); end
    if (o_rdy[0] !== 1'b0)  begin errors++; $display("FAIL hold_pending_full got %b want 0", o_rdy[0]); end
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      checks++;
      if (o_co[0] !== e_co[0]) begin errors++; $display("FAIL hold_co got %h want %h", o_co[0], e_co[0]); end
      if (o_fs[0] === 1'b1) begin
        seen = 1;
        checks++;
        if (o_co[0] !== 64'h3C) begin errors++; $display("FAIL hold_second_grid got %h want 3c", o_co[0]); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL hold_timeout got no frame_start want one"); end
  endtask

  task automatic test_ena_drop();
    for (int c = 0; c < 100 && !(e_x[0] == 4'd5 && e_de[0]); c++) tick();
    ena = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks += 2;
      if (o_de[i] !== 1'b0) begin errors++; $display("FAIL drop_de[%0d] got %b want 0", i, o_de[i]); end
      if (o_x[i] !== 4'd0)  begin errors++; $display("FAIL drop_x[%0d] got %0d want 0", i, o_x[i]); end
    end
    tick(); tick();
    ena = 1'b1;
    tick();
    checks += 4;
    if (o_fs[0] !== 1'b1)   begin errors++; $display("FAIL reena_fs got %b want 1", o_fs[0]); end
    if (o_x[0] !== 4'd0)    begin errors++; $display("FAIL reena_x got %0d want 0", o_x[0]); end
    if (o_de[0] !== 1'b1)   begin errors++; $display("FAIL reena_de got %b want 1", o_de[0]); end
    if (o_co[0] !== 64'h3C) begin errors++; $display("FAIL reena_display_kept got %h want 3c", o_co[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      ena = ($urandom_range(0, 39) != 0);
      if0.cells_valid = $urandom_range(0, 3) == 0;
      if1.cells_valid = $urandom_range(0, 3) == 0;
      if0.cells_in = {$urandom, $urandom};
      if1.cells_in = {$urandom, $urandom};
      tick();
      for (int i = 0; i < 2; i++) begin
        checks += 5;
        if (o_x[i] !== e_x[i])     begin errors++; $display("FAIL rnd_x[%0d] c=%0d got %0d want %0d", i, c, o_x[i], e_x[i]); end
        if (o_de[i] !== e_de[i])   begin errors++; $display("FAIL rnd_de[%0d] c=%0d got %b want %b", i, c, o_de[i], e_de[i]); end
        if (o_fs[i] !== e_fs[i])   begin errors++; $display("FAIL rnd_fs[%0d] c=%0d got %b want %b", i, c, o_fs[i], e_fs[i]); end
        if (o_co[i] !== e_co[i])   begin errors++; $display("FAIL rnd_co[%0d] c=%0d got %h want %h", i, c, o_co[i], e_co[i]); end
        if (o_rdy[i] !== e_rdy[i]) begin errors++; $display("FAIL rnd_rdy[%0d] c=%0d got %b want %b", i, c, o_rdy[i], e_rdy[i]); end
      end
    end
    if0.cells_valid = 1'b0;
    if1.cells_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found = 0;
    ena = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      tick();
      if (m_run[0] && !e_de[0]) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL areset_blank_timeout got none want BLANK"); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks += 5;
      if (o_x[i] !== 4'd0)   begin errors++; $display("FAIL areset_x[%0d] got %0d want 0", i, o_x[i]); end
      if (o_de[i] !== 1'b0)  begin errors++; $display("FAIL areset_de[%0d] got %b want 0", i, o_de[i]); end
      if (o_fs[i] !== 1'b0)  begin errors++; $display("FAIL areset_fs[%0d] got %b want 0", i, o_fs[i]); end
      if (o_co[i] !== 64'h0) begin errors++; $display("FAIL areset_co[%0d] got %h want 0", i, o_co[i]); end
      if (o_rdy[i] !== 1'b1) begin errors++; $display("FAIL areset_rdy[%0d] got %b want 1", i, o_rdy[i]); end
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks += 3;
    if (o_fs[0] !== 1'b1) begin errors++; $display("FAIL post_reset_fs got %b want 1", o_fs[0]); end
    if (o_de[1] !== 1'b1) begin errors++; $display("FAIL post_reset_de got %b want 1", o_de[1]); end
    if (o_x[0] !== 4'd0)  begin errors++; $display("FAIL post_reset_x got %0d want 0", o_x[0]); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_swap();
    test_hold_valid();
    test_ena_drop();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_scan_controller.md
# led_scan_controller

Scan sequencer that sits directly upstream of `led_array_driver`. It owns the column-multiplex timing and a double-buffered copy of the Conway cell grid. It takes new generations from the game-of-life core through a valid/ready handshake and swaps them in only at frame boundaries, so the display never tears. Each cycle it presents the column index `x`, the enable `drive_ena` and the stable grid `cells_out` to the driver.

## Interface
Parameters:
- `N`, 8, grid size; legal range 1..8.
- `COL_HOLD_CYCLES`, 1000, clock cycles each column is driven; must be ≥1.
- `BLANK_CYCLES`, 100, dead cycles between columns with the driver disabled (anti-ghosting); 0 is legal.
- `XBITS`, localparam = `$clog2(N)`; column index width is `XBITS+1`.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: level; scanning runs while high.
- `cells_in` input N*N: next generation from the game core.
- `cells_valid` input 1: `cells_in` is valid this cycle.
- `cells_ready` output 1: block can accept `cells_in` this cycle.
- `x` output XBITS+1: current column, 0..N-1.
- `drive_ena` output 1: enable to driver; high only while a column is being held.
- `cells_out` output N*N: display buffer; changes only at a frame start.
- `frame_start` output 1: one-cycle pulse on the first DRIVE cycle of column 0.

## Operation
- Two grid registers:
  - `pending` plus flag `pending_full`.
  - `display`, which drives `cells_out`.
- Handshake:
  - `cells_ready = ~pending_full`, combinational from the flag only.
  - Transfer occurs when `cells_valid & cells_ready`: `pending <= cells_in`, `pending_full <= 1`.
  - `cells_valid` while not ready: ignored; the core must hold it.
- FSM states, held in the package enum:
  - IDLE: `drive_ena=0`, `x=0`. If `ena` is high, go to DRIVE at column 0 and do a frame start.
  - DRIVE: `drive_ena=1` for exactly `COL_HOLD_CYCLES` cycles. Then go to BLANK, or straight to the next column if `BLANK_CYCLES==0`.
  - BLANK: `drive_ena=0` for exactly `BLANK_CYCLES` cycles, then go to DRIVE at the next column.
- Column advance: `x` increments on entry to the next DRIVE. After column N-1 it wraps to 0 and does a frame start.
- Frame start (entry to DRIVE at column 0):
  - `frame_start` pulses.
  - If `pending_full`: `display <= pending`, `pending_full <= 0` on that same edge.
- Simultaneous swap and `cells_valid`: `cells_ready` was low that cycle, so nothing is accepted. Ready rises the next cycle and the data is accepted then. No data is lost or duplicated.
- `ena` deasserted in any state: go to IDLE on the next edge (`drive_ena=0`, `x=0`). The hold/blank counter resets. `display` and `pending` are retained. Re-enabling starts a fresh frame at column 0.
- Counter: a single down-counter loaded with `COL_HOLD_CYCLES-1` or `BLANK_CYCLES-1` on state entry. Its width is `$clog2(max(COL_HOLD_CYCLES,BLANK_CYCLES,2))`.

## Timing
- Reset, asynchronous: state IDLE, `x=0`, `drive_ena=0`, `frame_start=0`, `cells_out=0`, `pending_full=0`. Therefore `cells_ready=1` during and after reset.
- Latency:
  - `ena` rising to first `drive_ena=1`: 1 cycle.
  - `ena` falling to `drive_ena=0`: 1 cycle.
- Column period: `COL_HOLD_CYCLES+BLANK_CYCLES`.
- Frame period: `N*(COL_HOLD_CYCLES+BLANK_CYCLES)`.
- `cells_out` is updated only on the edge where `frame_start` goes high. It is never updated mid-frame.
- All outputs except `cells_ready` are registered.

## Structure
- `led_scan_pkg`: the `scan_state_t` enum (IDLE, DRIVE, BLANK) and a helper function for the counter width.
- Sub-module `grid_double_buffer`: owns `pending`, `display`, `pending_full` and the handshake. It takes a `swap` strobe from the FSM.
- FSM and counter live in the top module.

## Test plan
All scenarios use N=8, COL_HOLD_CYCLES=4, BLANK_CYCLES=1.
1. Reset, then `ena=1` -> `drive_ena` high for 4 cycles, low for 1; `x` steps 0..7 and wraps to 0; `frame_start` pulses every 40 cycles.
2. Pulse `cells_valid` with `cells_in=64'hA5` mid-frame -> `cells_ready` drops the next cycle; `cells_out` stays 0 until the next `frame_start` edge, then equals `64'hA5`; `cells_ready` returns to 1.
3. Hold `cells_valid` with a second grid `64'h3C` while pending is full -> not accepted until the cycle after the swap; it appears one frame later; no loss.
4. Drop `ena` mid-DRIVE at `x=5` -> next cycle `drive_ena=0`, `x=0`; on re-enable, `frame_start` pulses and `x=0`.
5. Assert `rst_n=0` asynchronously mid-BLANK -> all outputs take reset values immediately, without waiting for a clock edge; `cells_ready=1`.
6. BLANK_CYCLES=0 build -> `drive_ena` never drops between columns; column period is 4 cycles.
